// File: rtl/onewire_slave_reset.sv
// rtl/onewire_slave_reset.sv - 1-Wire slave reset/presence responder
// Measures master reset lows on DQ and answers with a tPDH/tPDL presence pulse.
module onewire_slave_reset #(
  parameter int CLK_PER_US     = 50,
  parameter int RST_MIN_US     = 480,
  parameter int PDH_US         = 30,
  parameter int PDL_US         = 120,
  parameter int REC_TIMEOUT_US = 960
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic dq_in,
  output logic dq_out_en,
  output logic busy,
  output logic reset_detected,
  output logic presence_done,
  output logic bus_error
);

  localparam int RST_CYC = RST_MIN_US * CLK_PER_US;
  localparam int PDH_CYC = PDH_US * CLK_PER_US;
  localparam int PDL_CYC = PDL_US * CLK_PER_US;
  localparam int REC_CYC = REC_TIMEOUT_US * CLK_PER_US;
  localparam int MAX_A   = (RST_CYC > PDL_CYC) ? RST_CYC : PDL_CYC;
  localparam int CNT_MAX = (MAX_A > REC_CYC) ? MAX_A : REC_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] RST_THR  = CW'(RST_CYC);
  localparam logic [CW-1:0] PDH_LAST = CW'(PDH_CYC - 1);
  localparam logic [CW-1:0] PDL_LAST = CW'(PDL_CYC - 1);
  localparam logic [CW-1:0] REC_LAST = CW'(REC_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_SAT  = '1;

  typedef enum logic [2:0] {IDLE, LOW_MEAS, PDH, PDL, REC} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
  logic          dq_m, dq_s;
  logic          rd_nxt, pd_nxt, be_nxt;

  // Synchronizer idles high so a reset does not look like a bus low.
  always_ff @(posedge clk) begin
    if (!rst) begin
      dq_m           <= 1'b1;
      dq_s           <= 1'b1;
      state          <= IDLE;
      cnt            <= '0;
      reset_detected <= 1'b0;
      presence_done  <= 1'b0;
      bus_error      <= 1'b0;
    end else begin
      dq_m           <= dq_in;
      dq_s           <= dq_m;
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      reset_detected <= rd_nxt;
      presence_done  <= pd_nxt;
      bus_error      <= be_nxt;
    end
  end

  assign cnt_inc = (cnt == CNT_SAT) ? cnt : cnt + CNT_ONE;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_inc;
    rd_nxt    = 1'b0;
    pd_nxt    = 1'b0;
    be_nxt    = 1'b0;
    if (!en) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          cnt_nxt = '0;
          if (!dq_s) begin
            state_nxt = LOW_MEAS;
            cnt_nxt   = CNT_ONE;
          end
        end
        LOW_MEAS: begin
          if (dq_s) begin
            cnt_nxt = '0;
            if (cnt >= RST_THR) begin
              rd_nxt    = 1'b1;
              state_nxt = PDH;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
        PDH: begin
          // Master pulling low again means a fresh reset, not a time slot.
          if (!dq_s) begin
            state_nxt = LOW_MEAS;
            cnt_nxt   = CNT_ONE;
          end else if (cnt == PDH_LAST) begin
            state_nxt = PDL;
            cnt_nxt   = '0;
          end
        end
        PDL: begin
          if (cnt == PDL_LAST) begin
            state_nxt = REC;
            cnt_nxt   = '0;
          end
        end
        REC: begin
          if (dq_s) begin
            pd_nxt    = 1'b1;
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else if (cnt == REC_LAST) begin
            be_nxt    = 1'b1;
            state_nxt = LOW_MEAS;
            cnt_nxt   = CNT_ONE;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_comb begin
    dq_out_en = (state == PDL);
    busy      = (state != IDLE);
  end

endmodule
